// File: rtl/matmul_mem_master_if.sv
// Main-memory bus between the matrix-multiply initiator and the memory.
// The memory answers reads combinationally and captures writes while memwrite is high.
interface matmul_mem_master_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic              memread;
    logic              memwrite;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output memread,
        output memwrite,
        output address,
        output data_out,
        input  data_in
    );

    modport slave (
        input  memread,
        input  memwrite,
        input  address,
        input  data_out,
        output data_in
    );
endinterface

// File: rtl/matmul_mem_master.sv
// Bus initiator that computes C = A x B for two N x N matrices held in memory.
// Each C element takes one A read and one B read per dot-product term, followed by one write.
//
// state | meaning
// IDLE  | waiting for start; bus quiet
// RD_A  | read A[i][k] into a_reg
// RD_B  | read B[k][j], accumulate a_reg * B[k][j]
// WR    | write acc to C[i][j], advance j/i
// DONE  | one-cycle done pulse, then back to IDLE
module matmul_mem_master #(
    parameter int                N      = 3,
    parameter int                ADDR_W = 17,
    parameter int                DATA_W = 32,
    parameter logic [ADDR_W-1:0] A_BASE = 17'h00200,
    parameter logic [ADDR_W-1:0] B_BASE = 17'h00300,
    parameter logic [ADDR_W-1:0] C_BASE = 17'h00100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    matmul_mem_master_if.master   bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_B = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     i_q, i_d;
    logic [CW-1:0]     j_q, j_d;
    logic [CW-1:0]     k_q, k_d;
    logic [DATA_W-1:0] a_reg_q, a_reg_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic [ADDR_W-1:0] i_ext, j_ext, k_ext, n_ext;
    logic [ADDR_W-1:0] idx_a, idx_b, idx_c;

    assign i_ext = ADDR_W'(i_q);
    assign j_ext = ADDR_W'(j_q);
    assign k_ext = ADDR_W'(k_q);
    assign n_ext = ADDR_W'(N);
    assign idx_a = i_ext * n_ext + k_ext;
    assign idx_b = k_ext * n_ext + j_ext;
    assign idx_c = i_ext * n_ext + j_ext;

    // Next-state, counter and datapath update for the read/accumulate/write sequence
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        a_reg_d = a_reg_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_A;
                end
            end
            RD_A: begin
                a_reg_d = bus.data_in;
                state_d = RD_B;
            end
            RD_B: begin
                // product and sum both wrap at the data width
                acc_d = acc_q + a_reg_q * bus.data_in;
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = WR;
                end else begin
                    k_d     = k_q + ONE;
                    state_d = RD_A;
                end
            end
            WR: begin
                acc_d = '0;
                if ((i_q == LAST) && (j_q == LAST)) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = DONE;
                end else begin
                    if (j_q != LAST) begin
                        j_d = j_q + ONE;
                    end else begin
                        j_d = '0;
                        i_d = i_q + ONE;
                    end
                    state_d = RD_A;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and datapath registers; reset drops back to IDLE immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_reg_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_reg_q <= a_reg_d;
            acc_q   <= acc_d;
        end
    end

    // Bus and status outputs decoded purely from registered state and counters
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.address  = '0;
        bus.data_out = '0;
        case (state_q)
            RD_A: begin
                busy        = 1'b1;
                bus.memread = 1'b1;
                bus.address = A_BASE + (idx_a << 2);
            end
            RD_B: begin
                busy        = 1'b1;
                bus.memread = 1'b1;
                bus.address = B_BASE + (idx_b << 2);
            end
            WR: begin
                busy         = 1'b1;
                bus.memwrite = 1'b1;
                bus.address  = C_BASE + (idx_c << 2);
                bus.data_out = acc_q;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/matmul_mem_master.md
Name: matmul_mem_master

Overview:
- Initiator on the main-memory bus (memread/memwrite/address/data) that computes C = A × B for two N×N matrices held in memory.
- Reads A and B word by word, accumulates each dot product, and writes every C element back to the result region.
- Sits between the control path (start/done) and the main memory.
- The memory is the responder: reads are combinational (data valid in the same cycle as address with memread=1); writes are captured while memwrite=1.

Parameters:
- N, 3, matrix dimension (2..8).
- ADDR_W, 17, memory address width.
- DATA_W, 32, data word width.
- A_BASE, 17'h00200, byte address of A[0][0]; row-major, 4-byte stride.
- B_BASE, 17'h00300, byte address of B[0][0]; row-major, 4-byte stride.
- C_BASE, 17'h00100, byte address of C[0][0]; row-major, 4-byte stride.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin one multiply; sampled only in IDLE.
- busy  output  1  high while in RD_A/RD_B/WR.
- done  output  1  single-cycle pulse after the last C write.
- memread  output  1  memory read strobe.
- memwrite  output  1  memory write strobe.
- address  output  ADDR_W  memory byte address.
- data_in  input  DATA_W  read data from memory.
- data_out  output  DATA_W  write data to memory.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; i=j=k=0; a_reg=0; acc=0. While reset is asserted: busy=done=memread=memwrite=0, address=0, data_out=0.
- Counters: i = C row, j = C column, k = dot-product index; each is 0..N-1.
- Address generation:
  - A = A_BASE + 4·(i·N+k)
  - B = B_BASE + 4·(k·N+j)
  - C = C_BASE + 4·(i·N+j)
- Outputs are decoded from registered state and counters. memread and memwrite are never both 1.
- IDLE: all bus outputs 0. start=1 → RD_A on the next edge. Counters and acc are already 0.
- RD_A: memread=1, address=A addr. At the edge: a_reg <= data_in; go to RD_B.
- RD_B: memread=1, address=B addr. At the edge: acc <= acc + low32(a_reg × data_in).
  - If k==N-1: k<=0, go to WR.
  - Else: k<=k+1, go to RD_A.
- WR: memwrite=1, address=C addr, data_out=acc (data_out=0 in all other states). At the edge: acc<=0.
  - If j<N-1: j++.
  - Else: j<=0 and i++.
  - If i==N-1 and j==N-1: go to DONE (counters cleared to 0). Otherwise go to RD_A.
- DONE: done=1 and busy=0 for exactly one cycle; then IDLE.
- Latency:
  - (2N+1) cycles per element; N²·(2N+1) busy cycles total (63 for N=3).
  - With start sampled at edge 0: first RD_A is cycle 1, last WR is cycle N²(2N+1), done is high in the following cycle (cycle 64 for N=3).
- Arithmetic: unsigned 32×32 product truncated to the low 32 bits; accumulation wraps modulo 2^32. No overflow flag.
- start while busy or in DONE: ignored; it does not restart or queue.
- start held high continuously: a new multiply begins on the edge after DONE (the first IDLE cycle samples start).
- Reset mid-operation: immediate return to IDLE with all outputs 0. The partially computed element is not written. Already-written C elements are left as they are.
- data_in is ignored outside RD_A/RD_B.

Test Plan:
- Identity: A words 1..9, B = identity, N=3, pulse start.
  - Exactly 9 writes, values 1..9 to addresses 0x100, 0x104, …, 0x120 in order.
  - busy high cycles 1–63, done high only in cycle 64.
- General product: A=[1..9], B=[9..1] row-major.
  - C writes are 30, 24, 18, 84, 69, 54, 138, 114, 90.
  - Address trace for element C[0][0]: 0x200, 0x300, 0x204, 0x30C, 0x208, 0x318, then write to 0x100.
- Overflow: A[0][*]=32'hFFFFFFFF, B[*][0]=2.
  - C[0][0] written as 32'hFFFFFFFA (wrapped).
- Start while busy: pulse start again at cycles 10 and 63.
  - Write count stays at 9; done pulses once.
  - No new read is issued until start is reasserted in IDLE.
- Reset mid-operation: assert reset at cycle 20 (during element 2).
  - memread, memwrite and address are 0 the same cycle.
  - No write to 0x108.
  - A fresh start after release produces the full correct 9-write sequence.
- Bus protocol check, all tests:
  - memread & memwrite never both 1.
  - memwrite is high only at C-region addresses; memread only at A/B-region addresses.
